// File: rtl/si5345_config_sequencer.sv
// Si5345 configuration sequencer: streams a ROM register table into the SPI
// register engine (preamble, calibration delay, body), then polls until lock.
module si5345_config_sequencer #(
  parameter int unsigned NUM_REGS        = 512,
  parameter int unsigned ROM_AW          = 10,
  parameter int unsigned PREAMBLE_LEN    = 3,
  parameter int unsigned DELAY_CYCLES    = 30000000,
  parameter logic [15:0] STATUS_ADDR     = 16'h000E,
  parameter logic [7:0]  STATUS_MASK     = 8'h02,
  parameter int unsigned POLL_GAP_CYCLES = 100000,
  parameter int unsigned POLL_LIMIT      = 1000
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [23:0]       rom_data_i,
  output logic              eng_start_o,
  output logic              eng_rw_o,
  output logic [15:0]       eng_addr_o,
  output logic [7:0]        eng_wdata_o,
  input  logic [7:0]        eng_rdata_i,
  input  logic              eng_busy_i,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              locked_o,
  output logic              error_o,
  output logic [ROM_AW:0]   entry_cnt_o,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_DONE, S_DELAY,
    S_POLL_ISSUE, S_POLL_WAIT, S_POLL_GAP, S_FINISH
  } state_t;

  localparam logic [ROM_AW:0]   NUM_REGS_C = NUM_REGS[ROM_AW:0];
  localparam logic [ROM_AW:0]   PREAMBLE_C = PREAMBLE_LEN[ROM_AW:0];
  localparam logic [ROM_AW:0]   CNT_ONE    = {{ROM_AW{1'b0}}, 1'b1};
  localparam logic [ROM_AW-1:0] ADDR_ONE   = {{(ROM_AW-1){1'b0}}, 1'b1};
  // A zero-length wait still spends one cycle in its state.
  localparam logic [31:0] DELAY_LAST = (DELAY_CYCLES == 0) ? 32'd0 : DELAY_CYCLES - 32'd1;
  localparam logic [31:0] GAP_LAST   = (POLL_GAP_CYCLES == 0) ? 32'd0 : POLL_GAP_CYCLES - 32'd1;

  state_t          state;
  logic [31:0]     delay_cnt;
  logic [31:0]     poll_cnt;
  logic [ROM_AW:0] entry_next;

  assign entry_next = entry_cnt_o + CNT_ONE;
  assign state_dbg  = state;

  // Engine handshake: eng_start_o is a one-cycle request raised only while
  // eng_busy_i = 0 and nothing is outstanding; eng_done_i retires it. The
  // command fields (rw/addr/wdata) are held stable until that eng_done_i.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rom_addr_o  <= '0;
      eng_start_o <= 1'b0;
      eng_rw_o    <= 1'b0;
      eng_addr_o  <= '0;
      eng_wdata_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      locked_o    <= 1'b0;
      error_o     <= 1'b0;
      entry_cnt_o <= '0;
      delay_cnt   <= '0;
      poll_cnt    <= '0;
    end else begin
      eng_start_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            locked_o    <= 1'b0;
            error_o     <= 1'b0;
            entry_cnt_o <= '0;
            busy_o      <= 1'b1;
            rom_addr_o  <= '0;
            poll_cnt    <= '0;
            state       <= (NUM_REGS == 0) ? S_POLL_ISSUE : S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          eng_addr_o  <= rom_data_i[23:8];
          eng_wdata_o <= rom_data_i[7:0];
          eng_rw_o    <= 1'b0;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!eng_busy_i) begin
            eng_start_o <= 1'b1;
            state       <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (eng_done_i) begin
            entry_cnt_o <= entry_next;
            if (entry_next == NUM_REGS_C) begin
              state <= S_POLL_ISSUE;
            end else if (PREAMBLE_LEN != 0 && entry_next == PREAMBLE_C) begin
              delay_cnt <= '0;
              state     <= S_DELAY;
            end else begin
              rom_addr_o <= rom_addr_o + ADDR_ONE;
              state      <= S_FETCH;
            end
          end
        end
        S_DELAY: begin
          if (delay_cnt >= DELAY_LAST) begin
            if (entry_cnt_o == NUM_REGS_C) begin
              state <= S_POLL_ISSUE;
            end else begin
              rom_addr_o <= rom_addr_o + ADDR_ONE;
              state      <= S_FETCH;
            end
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end
        S_POLL_ISSUE: begin
          eng_rw_o    <= 1'b1;
          eng_addr_o  <= STATUS_ADDR;
          eng_wdata_o <= '0;
          if (!eng_busy_i) begin
            eng_start_o <= 1'b1;
            poll_cnt    <= poll_cnt + 32'd1;
            state       <= S_POLL_WAIT;
          end
        end
        S_POLL_WAIT: begin
          if (eng_done_i) begin
            if ((eng_rdata_i & STATUS_MASK) == 8'h00) begin
              locked_o <= 1'b1;
              state    <= S_FINISH;
            end else if (poll_cnt == POLL_LIMIT) begin
              error_o <= 1'b1;
              state   <= S_FINISH;
            end else begin
              delay_cnt <= '0;
              state     <= S_POLL_GAP;
            end
          end
        end
        S_POLL_GAP: begin
          if (delay_cnt >= GAP_LAST) state <= S_POLL_ISSUE;
          else delay_cnt <= delay_cnt + 32'd1;
        end
        S_FINISH: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_si5345_config_sequencer.sv
// Directed bench for si5345_config_sequencer: ROM + register-engine models,
// per-scenario tasks with inline checks against hand-computed expectations.
module tb_si5345_config_sequencer;

  logic        sys_clk;
  logic        reset_n;
  logic        start_i;
  logic [9:0]  rom_addr_o;
  logic [23:0] rom_data_i;
  logic        eng_start_o, eng_rw_o;
  logic [15:0] eng_addr_o;
  logic [7:0]  eng_wdata_o, eng_rdata_i;
  logic        eng_busy_i, eng_done_i;
  logic        busy_o, done_o, locked_o, error_o;
  logic [10:0] entry_cnt_o;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] rom [0:15];
  logic [24:0] exp_q[$];

  // main engine model state
  logic [24:0] log_q[$];
  int          start_cyc_q[$];
  int          done_cyc_q[$];
  logic [7:0]  stat_q[$];
  logic [7:0]  stat_default = 8'h00;
  int          busy_pre = 0;
  int          hold = 0;
  int          lat = 0;
  bit          outstanding = 0;
  int          proto_err = 0;
  int          done_pulses = 0;
  bit          done_prev = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 24'h0;
    rom[0] = 24'h0B24C0;
    rom[1] = 24'h0B2500;
    rom[2] = 24'h054001;
    rom[3] = 24'h0B24C3;
  end

  always @(posedge sys_clk) rom_data_i <= rom[rom_addr_o[3:0]];

  si5345_config_sequencer #(
    .NUM_REGS(4), .ROM_AW(10), .PREAMBLE_LEN(2), .DELAY_CYCLES(50),
    .STATUS_ADDR(16'h000E), .STATUS_MASK(8'h02), .POLL_GAP_CYCLES(10), .POLL_LIMIT(5)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start_i(start_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .eng_start_o(eng_start_o), .eng_rw_o(eng_rw_o), .eng_addr_o(eng_addr_o),
    .eng_wdata_o(eng_wdata_o), .eng_rdata_i(eng_rdata_i), .eng_busy_i(eng_busy_i),
    .eng_done_i(eng_done_i), .busy_o(busy_o), .done_o(done_o), .locked_o(locked_o),
    .error_o(error_o), .entry_cnt_o(entry_cnt_o), .state_dbg(state_dbg)
  );

  // Engine model: 3-cycle latency, optional busy hold after each completion,
  // flags any start while busy/outstanding or command change before done.
  always @(negedge sys_clk) begin
    eng_done_i = 1'b0;
    if (done_o) begin
      done_pulses++;
      if (done_prev) proto_err++;
    end
    done_prev = done_o;
    if (!reset_n) begin
      outstanding = 0;
      hold = 0;
      eng_busy_i = 1'b0;
    end else if (eng_start_o) begin
      if (eng_busy_i || outstanding) proto_err++;
      log_q.push_back({eng_rw_o, eng_addr_o, eng_wdata_o});
      start_cyc_q.push_back(cyc);
      if (eng_rw_o) begin
        if (stat_q.size() > 0) eng_rdata_i = stat_q.pop_front();
        else eng_rdata_i = stat_default;
      end
      outstanding = 1;
      lat = 3;
      eng_busy_i = 1'b1;
    end else if (outstanding) begin
      if (lat > 1) begin
        lat--;
      end else begin
        if ({eng_rw_o, eng_addr_o, eng_wdata_o} != log_q[$]) proto_err++;
        eng_done_i = 1'b1;
        outstanding = 0;
        done_cyc_q.push_back(cyc);
        hold = busy_pre;
        eng_busy_i = (busy_pre > 0);
      end
    end else if (hold > 0) begin
      hold--;
      eng_busy_i = (hold > 0);
    end
  end

  // Two small side instances: empty table, and no preamble with a long delay.
  logic        z_go, z_start, z_rw, z_busy, z_done, z_busy_o, z_done_o, z_locked, z_error;
  logic [9:0]  z_rom_addr;
  logic [15:0] z_addr;
  logic [7:0]  z_wdata;
  logic [10:0] z_cnt;
  logic [3:0]  z_state;
  logic [24:0] z_log_q[$];
  int          z_lat = 0;

  logic        p_go, p_start, p_rw, p_busy, p_done, p_busy_o, p_done_o, p_locked, p_error;
  logic [9:0]  p_rom_addr;
  logic [23:0] p_rom_data;
  logic [15:0] p_addr;
  logic [7:0]  p_wdata;
  logic [10:0] p_cnt;
  logic [3:0]  p_state;
  logic [24:0] p_log_q[$];
  int          p_lat = 0;
  logic [23:0] zero24 = 24'h0;
  logic [7:0]  zero8 = 8'h0;

  always @(posedge sys_clk) p_rom_data <= rom[p_rom_addr[3:0]];

  si5345_config_sequencer #(
    .NUM_REGS(0), .ROM_AW(10), .PREAMBLE_LEN(2), .DELAY_CYCLES(50),
    .POLL_GAP_CYCLES(10), .POLL_LIMIT(5)
  ) dut_z (
    .sys_clk(sys_clk), .reset_n(reset_n), .start_i(z_go),
    .rom_addr_o(z_rom_addr), .rom_data_i(zero24),
    .eng_start_o(z_start), .eng_rw_o(z_rw), .eng_addr_o(z_addr),
    .eng_wdata_o(z_wdata), .eng_rdata_i(zero8), .eng_busy_i(z_busy),
    .eng_done_i(z_done), .busy_o(z_busy_o), .done_o(z_done_o), .locked_o(z_locked),
    .error_o(z_error), .entry_cnt_o(z_cnt), .state_dbg(z_state)
  );

  si5345_config_sequencer #(
    .NUM_REGS(4), .ROM_AW(10), .PREAMBLE_LEN(0), .DELAY_CYCLES(1000),
    .POLL_GAP_CYCLES(10), .POLL_LIMIT(5)
  ) dut_p (
    .sys_clk(sys_clk), .reset_n(reset_n), .start_i(p_go),
    .rom_addr_o(p_rom_addr), .rom_data_i(p_rom_data),
    .eng_start_o(p_start), .eng_rw_o(p_rw), .eng_addr_o(p_addr),
    .eng_wdata_o(p_wdata), .eng_rdata_i(zero8), .eng_busy_i(p_busy),
    .eng_done_i(p_done), .busy_o(p_busy_o), .done_o(p_done_o), .locked_o(p_locked),
    .error_o(p_error), .entry_cnt_o(p_cnt), .state_dbg(p_state)
  );

  always @(negedge sys_clk) begin
    z_done = 1'b0;
    if (!reset_n) begin
      z_lat = 0; z_busy = 1'b0;
    end else if (z_start) begin
      z_log_q.push_back({z_rw, z_addr, z_wdata}); z_lat = 3; z_busy = 1'b1;
    end else if (z_lat > 0) begin
      z_lat--;
      if (z_lat == 0) begin z_done = 1'b1; z_busy = 1'b0; end
    end
  end

  always @(negedge sys_clk) begin
    p_done = 1'b0;
    if (!reset_n) begin
      p_lat = 0; p_busy = 1'b0;
    end else if (p_start) begin
      p_log_q.push_back({p_rw, p_addr, p_wdata}); p_lat = 3; p_busy = 1'b1;
    end else if (p_lat > 0) begin
      p_lat--;
      if (p_lat == 0) begin p_done = 1'b1; p_busy = 1'b0; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    log_q.delete(); start_cyc_q.delete(); done_cyc_q.delete();
    stat_q.delete(); exp_q.delete();
    done_pulses = 0; proto_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge sys_clk); start_i = 1'b1;
    @(negedge sys_clk); start_i = 1'b0;
  endtask

  task automatic wait_main_done(input int budget, output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < budget) begin
      @(negedge sys_clk); n++;
      if (done_o === 1'b1) ok = 1;
    end
  endtask

  function automatic logic [24:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 25'h1FFFFFF;
  endfunction

  function automatic void load_exp_full();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, rom[i]});
    exp_q.push_back({1'b1, 16'h000E, 8'h00});
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; start_i = 1'b0; z_go = 1'b0; p_go = 1'b0;
    eng_busy_i = 1'b0; eng_done_i = 1'b0; eng_rdata_i = 8'h00;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({busy_o, done_o, locked_o, error_o, eng_start_o, eng_rw_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 000000",
        {busy_o, done_o, locked_o, error_o, eng_start_o, eng_rw_o});
    end
    checks++;
    if (entry_cnt_o !== 11'd0) begin errors++; $display("FAIL reset_entry_cnt: got %0d required 0", entry_cnt_o); end
    checks++;
    if (rom_addr_o !== 10'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d required 0", rom_addr_o); end
    checks++;
    if (eng_addr_o !== 16'h0) begin errors++; $display("FAIL reset_eng_addr: got %h required 0000", eng_addr_o); end
    checks++;
    if (eng_wdata_o !== 8'h0) begin errors++; $display("FAIL reset_eng_wdata: got %h required 00", eng_wdata_o); end
    checks++;
    if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d required 0 (idle)", state_dbg); end
    @(negedge sys_clk); reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_basic_sequence();
    bit ok;
    logic [24:0] exp_v;
    clear_logs();
    load_exp_full();
    pulse_start();
    wait_main_done(3000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_done: done_o never seen, required pulse"); end
    checks++;
    if (locked_o !== 1'b1 || error_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_status: locked=%b error=%b busy=%b required 1 0 0", locked_o, error_o, busy_o);
    end
    checks++;
    if (entry_cnt_o !== 11'd4) begin errors++; $display("FAIL basic_entry_cnt: got %0d required 4", entry_cnt_o); end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (log_q.size() != 5) begin errors++; $display("FAIL basic_txn_count: got %0d required 5", log_q.size()); end
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (log_at(i) !== exp_v) begin
        errors++; $display("FAIL basic_txn%0d: got %h required %h", i, log_at(i), exp_v);
      end
    end
    // plain fetch/latch/issue after a done, and 50 delay cycles before entry 2
    checks++;
    if (start_cyc_q.size() < 3 || start_cyc_q[1] - done_cyc_q[0] != 4) begin
      errors++; $display("FAIL basic_fetch_gap: got %0d required 4",
        (start_cyc_q.size() < 3) ? -1 : start_cyc_q[1] - done_cyc_q[0]);
    end
    checks++;
    if (start_cyc_q.size() < 3 || start_cyc_q[2] - done_cyc_q[1] != 54) begin
      errors++; $display("FAIL basic_delay_gap: got %0d required 54 (50 delay + 4)",
        (start_cyc_q.size() < 3) ? -1 : start_cyc_q[2] - done_cyc_q[1]);
    end
    checks++;
    if (done_pulses != 1 || proto_err != 0) begin
      errors++; $display("FAIL basic_protocol: done_pulses=%0d proto_err=%0d required 1 0", done_pulses, proto_err);
    end
  endtask

  task automatic test_poll_retry();
    bit ok;
    int reads;
    clear_logs();
    stat_q.push_back(8'h02); stat_q.push_back(8'h02);
    stat_default = 8'h00;
    pulse_start();
    wait_main_done(3000, ok);
    checks++;
    if (ok !== 1'b1 || locked_o !== 1'b1 || error_o !== 1'b0) begin
      errors++; $display("FAIL retry_status: done=%b locked=%b error=%b required 1 1 0", ok, locked_o, error_o);
    end
    reads = 0;
    foreach (log_q[i]) if (log_q[i][24]) reads++;
    checks++;
    if (reads != 3 || log_q.size() != 7) begin
      errors++; $display("FAIL retry_reads: reads=%0d txns=%0d required 3 7", reads, log_q.size());
    end
    for (int i = 4; i < 6; i++) begin
      checks++;
      if (start_cyc_q.size() < 7 || start_cyc_q[i+1] - done_cyc_q[i] != 12) begin
        errors++; $display("FAIL retry_gap%0d: got %0d required 12 (10 gap + 2)", i,
          (start_cyc_q.size() < 7) ? -1 : start_cyc_q[i+1] - done_cyc_q[i]);
      end
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_poll_limit();
    bit ok;
    int reads;
    clear_logs();
    stat_default = 8'h02;
    pulse_start();
    wait_main_done(3000, ok);
    checks++;
    if (ok !== 1'b1 || error_o !== 1'b1 || locked_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL limit_status: done=%b error=%b locked=%b busy=%b required 1 1 0 0",
        ok, error_o, locked_o, busy_o);
    end
    repeat (3) @(negedge sys_clk);
    reads = 0;
    foreach (log_q[i]) if (log_q[i][24]) reads++;
    checks++;
    if (reads != 5) begin errors++; $display("FAIL limit_reads: got %0d required 5", reads); end
    checks++;
    if (done_pulses != 1) begin errors++; $display("FAIL limit_done_pulses: got %0d required 1", done_pulses); end
    stat_default = 8'h00;
  endtask

  task automatic test_busy_hold();
    bit ok;
    int t0;
    logic [24:0] exp_v;
    clear_logs();
    load_exp_full();
    busy_pre = 20;
    @(negedge sys_clk);
    hold = 20; eng_busy_i = 1'b1; t0 = cyc;
    pulse_start();
    repeat (40) @(negedge sys_clk);
    pulse_start();
    wait_main_done(4000, ok);
    checks++;
    if (ok !== 1'b1 || locked_o !== 1'b1 || entry_cnt_o !== 11'd4) begin
      errors++; $display("FAIL busy_status: done=%b locked=%b entry_cnt=%0d required 1 1 4", ok, locked_o, entry_cnt_o);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (start_cyc_q.size() < 1 || start_cyc_q[0] - t0 < 20) begin
      errors++; $display("FAIL busy_first_start: got %0d cycles after busy, required >= 20",
        (start_cyc_q.size() < 1) ? -1 : start_cyc_q[0] - t0);
    end
    checks++;
    if (proto_err != 0) begin errors++; $display("FAIL busy_protocol: got %0d violations required 0", proto_err); end
    checks++;
    if (log_q.size() != 5 || done_pulses != 1) begin
      errors++; $display("FAIL busy_restart_ignored: txns=%0d done_pulses=%0d required 5 1", log_q.size(), done_pulses);
    end
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (log_at(i) !== exp_v) begin errors++; $display("FAIL busy_txn%0d: got %h required %h", i, log_at(i), exp_v); end
    end
    busy_pre = 0;
    repeat (25) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clear_logs();
    pulse_start();
    n = 0;
    while (done_cyc_q.size() < 2 && n < 500) begin @(negedge sys_clk); n++; end
    repeat (10) @(negedge sys_clk);
    checks++;
    if (busy_o !== 1'b1 || entry_cnt_o !== 11'd2) begin
      errors++; $display("FAIL midrst_pre: busy=%b entry_cnt=%0d required 1 2", busy_o, entry_cnt_o);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, locked_o, error_o, eng_start_o, eng_rw_o, entry_cnt_o, rom_addr_o, eng_addr_o, eng_wdata_o} !== '0) begin
      errors++; $display("FAIL midrst_outputs: busy=%b entry_cnt=%0d rom_addr=%0d eng_addr=%h required all 0",
        busy_o, entry_cnt_o, rom_addr_o, eng_addr_o);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (done_pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_pulses); end
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    clear_logs();
    pulse_start();
    wait_main_done(3000, ok);
    checks++;
    if (ok !== 1'b1 || locked_o !== 1'b1) begin errors++; $display("FAIL midrst_replay_done: done=%b locked=%b required 1 1", ok, locked_o); end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (log_q.size() != 5 || log_at(0) !== {1'b0, rom[0]}) begin
      errors++; $display("FAIL midrst_replay_txns: count=%0d first=%h required 5 %h", log_q.size(), log_at(0), {1'b0, rom[0]});
    end
  endtask

  task automatic test_zero_regs();
    int n;
    z_log_q.delete();
    @(negedge sys_clk); z_go = 1'b1;
    @(negedge sys_clk); z_go = 1'b0;
    n = 0;
    while (z_done_o !== 1'b1 && n < 500) begin @(negedge sys_clk); n++; end
    checks++;
    if (z_done_o !== 1'b1 || z_locked !== 1'b1 || z_cnt !== 11'd0) begin
      errors++; $display("FAIL zero_status: done=%b locked=%b entry_cnt=%0d required 1 1 0", z_done_o, z_locked, z_cnt);
    end
    checks++;
    if (z_log_q.size() != 1 || z_log_q[0] !== {1'b1, 16'h000E, 8'h00}) begin
      errors++; $display("FAIL zero_txns: count=%0d first=%h required 1 %h", z_log_q.size(),
        (z_log_q.size() > 0) ? z_log_q[0] : 25'h0, {1'b1, 16'h000E, 8'h00});
    end
  endtask

  task automatic test_no_preamble();
    int n;
    p_log_q.delete();
    @(negedge sys_clk); p_go = 1'b1;
    @(negedge sys_clk); p_go = 1'b0;
    // five transactions at ~7 cycles each: a 1000-cycle delay cannot fit
    n = 0;
    while (p_done_o !== 1'b1 && n < 200) begin @(negedge sys_clk); n++; end
    checks++;
    if (p_done_o !== 1'b1 || p_locked !== 1'b1 || p_cnt !== 11'd4) begin
      errors++; $display("FAIL nopre_status: done=%b locked=%b entry_cnt=%0d within 200 cycles, required 1 1 4",
        p_done_o, p_locked, p_cnt);
    end
    checks++;
    if (p_log_q.size() != 5 || p_log_q[3] !== {1'b0, rom[3]}) begin
      errors++; $display("FAIL nopre_txns: count=%0d last_write=%h required 5 %h", p_log_q.size(),
        (p_log_q.size() > 3) ? p_log_q[3] : 25'h0, {1'b0, rom[3]});
    end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_poll_retry();
    test_poll_limit();
    test_busy_hold();
    test_reset_mid();
    test_zero_regs();
    test_no_preamble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/si5345_config_sequencer.md
Name: si5345_config_sequencer

Overview:
- Walks a register-configuration table stored in an external synchronous ROM and issues each entry as a register write to the Si5345 SPI register-access engine.
- Sequence: preamble writes, calibration delay, body writes, then status polling until the device reports lock.
- Sits between the board-level init/VIO control and the single-register SPI write/read engine, and is the only master of that engine during configuration.

Parameters:
- NUM_REGS, 512, total table entries (0..2^ROM_AW).
- ROM_AW, 10, ROM address width.
- PREAMBLE_LEN, 3, entries written before the calibration delay.
- DELAY_CYCLES, 30000000, sys_clk cycles of the post-preamble delay (300 ms at 100 MHz); 32-bit counter.
- STATUS_ADDR, 16'h000E, register read during lock polling.
- STATUS_MASK, 8'h02, bits that must read 0 for lock.
- POLL_GAP_CYCLES, 100000, idle cycles between status reads.
- POLL_LIMIT, 1000, maximum status reads before error.

Ports:
- sys_clk  in  1  system clock
- reset_n  in  1  reset
- start_i  in  1  pulse or level; a rising-edge-independent sample starts a sequence when idle
- rom_addr_o  out  ROM_AW  table index
- rom_data_i  in  24  {reg_addr[15:0], value[7:0]}, valid 1 cycle after rom_addr_o changes
- eng_start_o  out  1  single-cycle start to register engine
- eng_rw_o  out  1  1 = read, 0 = write
- eng_addr_o  out  16  register address
- eng_wdata_o  out  8  write value
- eng_rdata_i  in  8  read value, valid when eng_done_i = 1
- eng_busy_i  in  1  engine busy
- eng_done_i  in  1  engine single-cycle completion pulse
- busy_o  out  1  sequence in progress
- done_o  out  1  single-cycle pulse at sequence end (success or error)
- locked_o  out  1  last sequence ended with lock
- error_o  out  1  last sequence hit POLL_LIMIT
- entry_cnt_o  out  ROM_AW+1  entries written so far

Behaviour:
- Reset: reset_n is asynchronous, active-low; sys_clk is the clock.
  - All outputs are 0, state is IDLE, all counters are 0.
  - Assertion mid-sequence aborts immediately, with no completion pulse.
- IDLE
  - If start_i = 1: clear locked_o, error_o and entry_cnt_o; set busy_o; set rom_addr_o = 0.
  - If NUM_REGS = 0, go to POLL_ISSUE; otherwise go to FETCH.
  - start_i is ignored while busy_o = 1.
- FETCH: wait 1 cycle for ROM latency.
- LATCH: register rom_data_i into eng_addr_o/eng_wdata_o, set eng_rw_o = 0, go to ISSUE.
- ISSUE: when eng_busy_i = 0, pulse eng_start_o for exactly 1 cycle, then go to WAIT_DONE.
  - eng_addr_o, eng_wdata_o and eng_rw_o stay stable from LATCH until eng_done_i.
- WAIT_DONE: on eng_done_i, increment entry_cnt_o, then choose the next state:
  - entry_cnt_o (new) = NUM_REGS: go to POLL_ISSUE.
  - entry_cnt_o (new) = PREAMBLE_LEN and PREAMBLE_LEN is not 0: go to DELAY.
  - Otherwise: increment rom_addr_o and go to FETCH.
- DELAY
  - Count DELAY_CYCLES cycles (DELAY_CYCLES = 0 means exactly 1 cycle in this state).
  - Then increment rom_addr_o and go to FETCH, or go to POLL_ISSUE if no entries remain.
- POLL_ISSUE
  - eng_rw_o = 1, eng_addr_o = STATUS_ADDR, eng_wdata_o = 0.
  - Start is issued as in ISSUE; increment the poll counter; go to POLL_WAIT.
- POLL_WAIT: on eng_done_i, evaluate eng_rdata_i:
  - (eng_rdata_i & STATUS_MASK) = 0: set locked_o and go to FINISH.
  - Otherwise, if poll counter = POLL_LIMIT: set error_o and go to FINISH.
  - Otherwise: go to POLL_GAP.
- POLL_GAP: wait POLL_GAP_CYCLES cycles, then go to POLL_ISSUE.
- FINISH: clear busy_o, pulse done_o for 1 cycle, return to IDLE.
  - locked_o and error_o hold until the next start.
- eng_done_i outside WAIT_DONE/POLL_WAIT is ignored.
- eng_start_o never asserts while eng_busy_i = 1, and never twice without an intervening eng_done_i.
- Latency: a write entry takes 2 cycles of ROM fetch/latch plus engine time plus 1 cycle. No entry is skipped or repeated.

Test Plan:
- Parameters NUM_REGS = 4, PREAMBLE_LEN = 2, DELAY_CYCLES = 50; ROM holds {0x0B24,0xC0},{0x0B25,0x00},{0x0540,0x01},{0x0B24,0xC3}; engine model returns status 0x00.
  - Required: 4 writes in ROM order with exact addr/data.
  - Required: at least 50 cycles gap between write 2 done and write 3 start.
  - Required: then 1 read of 0x000E, done_o pulse, locked_o = 1, error_o = 0, entry_cnt_o = 4.
- Status model returns 0x02, 0x02, then 0x00 with POLL_GAP_CYCLES = 10 -> exactly 3 reads spaced at least 10 cycles apart; locked_o = 1.
- Status always 0x02, POLL_LIMIT = 5 -> exactly 5 reads, then done_o pulse with error_o = 1, locked_o = 0, busy_o = 0.
- eng_busy_i held high 20 cycles before each start -> eng_start_o is asserted only after busy drops, exactly 1 cycle; start_i pulsed mid-sequence has no effect.
- reset_n asserted during DELAY -> all outputs 0 immediately, no done_o pulse; a new start_i replays from entry 0.
- NUM_REGS = 0 -> no writes, poll read issued directly; PREAMBLE_LEN = 0 -> no delay inserted.
